// File: rtl/dtc_sched_pkg.sv
// Shared types and the round-robin pick helper for the classifier-core scheduler.
package dtc_sched_pkg;

  localparam int CLS_W   = 3;
  localparam int NCLS    = 2 ** CLS_W;
  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic       any;
    logic [2:0] idx;
  } pick_t;

  // First set bit of req searching upward from last+1, wrapping at nreq.
  function automatic pick_t rr_pick(input logic [7:0] req,
                                    input logic [2:0] last,
                                    input int         nreq);
    pick_t p;
    int    j;
    p.any = 1'b0;
    p.idx = 3'd0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      j = int'(last) + k;
      if (j >= nreq) begin
        j = j - nreq;
      end else begin
        j = j;
      end
      if ((k <= nreq) && !p.any && req[j[2:0]]) begin
        p.any = 1'b1;
        p.idx = j[2:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/dtc_rr_arb.sv
// Combinational round-robin arbiter: request vector plus last grant -> one-hot grant.
module dtc_rr_arb #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_last,
  output logic [NREQ-1:0]         o_gnt,
  output logic [$clog2(NREQ)-1:0] o_idx,
  output logic                    o_any
);
  import dtc_sched_pkg::*;

  localparam int IDW = $clog2(NREQ);

  logic [MAX_REQ-1:0] w_req8;
  logic [2:0]         w_last3;
  pick_t              w_pick;

  // Widen the request/last-grant to the helper's fixed 8-requester form and pick.
  always_comb begin
    w_req8             = 8'd0;
    w_req8[NREQ-1:0]   = i_req;
    w_last3            = 3'd0;
    w_last3[IDW-1:0]   = i_last;
    w_pick             = rr_pick(w_req8, w_last3, NREQ);
  end

  // Expand the picked index to a one-hot grant; no grant when nothing is requesting.
  always_comb begin
    o_any = w_pick.any;
    o_idx = w_pick.idx[IDW-1:0];
    for (int i = 0; i < NREQ; i++) begin
      o_gnt[i] = w_pick.any && (w_pick.idx == 3'(i));
    end
  end

endmodule

// File: rtl/dtc_rr_sched.sv
// Round-robin scheduler sharing one external decision-tree classifier core among
// NREQ requesters, with a registered core input, a held result and per-class counters.
module dtc_rr_sched #(
  parameter int NREQ  = 4,
  parameter int IN_W  = 12,
  parameter int CLS_W = 3,
  parameter int CNT_W = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NREQ-1:0]               req_valid,
  output logic [NREQ-1:0]               req_ready,
  input  logic [NREQ*IN_W-1:0]          req_data,
  output logic [IN_W-1:0]               dt_inp,
  input  logic [CLS_W-1:0]              dt_outp,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [CLS_W-1:0]              rsp_cls,
  output logic [$clog2(NREQ)-1:0]       rsp_id,
  input  logic                          stat_clr,
  output logic [(2**CLS_W)*CNT_W-1:0]   stat_cnt
);
  import dtc_sched_pkg::*;

  localparam int IDW   = $clog2(NREQ);
  localparam int N_CLS = 2 ** CLS_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [IDW-1:0]   r_last;
  logic [IDW-1:0]   r_id;
  logic [IDW-1:0]   r_rsp_id;
  logic [IN_W-1:0]  r_dt_inp;
  logic [CLS_W-1:0] r_rsp_cls;
  logic             r_rsp_valid;
  logic [CNT_W-1:0] r_cnt [N_CLS];

  logic [NREQ-1:0]  w_gnt;
  logic [IDW-1:0]   w_idx;
  logic             w_any;
  logic             w_fire;
  logic             w_open;
  logic [IN_W-1:0]  w_sel_data;

  dtc_rr_arb #(.NREQ(NREQ)) u_arb (
    .i_req  (req_valid),
    .i_last (r_last),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  // Arbitration window: idle, or the held result is being consumed this cycle.
  always_comb begin
    w_fire     = (r_state == HOLD) && rsp_ready;
    w_open     = rst_n && ((r_state == IDLE) || w_fire);
    w_sel_data = req_data[w_idx*IN_W +: IN_W];
    if (w_open) begin
      req_ready = w_gnt;
    end else begin
      req_ready = {NREQ{1'b0}};
    end
  end

  // Scheduler FSM: accept a sample, give the core one cycle to settle, hold the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_last      <= IDW'(NREQ - 1);
      r_id        <= {IDW{1'b0}};
      r_rsp_id    <= {IDW{1'b0}};
      r_dt_inp    <= {IN_W{1'b0}};
      r_rsp_cls   <= {CLS_W{1'b0}};
      r_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_dt_inp <= w_sel_data;
            r_id     <= w_idx;
            r_last   <= w_idx;
            r_state  <= EVAL;
          end
        end
        EVAL: begin
          r_rsp_cls   <= dt_outp;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= HOLD;
        end
        HOLD: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            if (w_any) begin
              r_dt_inp <= w_sel_data;
              r_id     <= w_idx;
              r_last   <= w_idx;
              r_state  <= EVAL;
            end else begin
              r_state  <= IDLE;
            end
          end
        end
        default: begin
          r_state     <= IDLE;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  // Per-class hit counters: saturate at all-ones, clear has priority over a hit.
  always_ff @(posedge clk) begin
    if (!rst_n || stat_clr) begin
      for (int k = 0; k < N_CLS; k++) begin
        r_cnt[k] <= {CNT_W{1'b0}};
      end
    end else if (w_fire && (r_cnt[r_rsp_cls] != CNT_MAX)) begin
      r_cnt[r_rsp_cls] <= r_cnt[r_rsp_cls] + CNT_ONE;
    end
  end

  for (genvar k = 0; k < N_CLS; k++) begin : g_stat
    assign stat_cnt[k*CNT_W +: CNT_W] = r_cnt[k];
  end

  assign dt_inp    = r_dt_inp;
  assign rsp_valid = r_rsp_valid;
  assign rsp_cls   = r_rsp_cls;
  assign rsp_id    = r_rsp_id;

endmodule
